// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bus arbiter.
// FSM encoding, master ids and the MMIO address map.
package mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [31:0] GPIO_ADDR = 32'h8000_0000;

endpackage

// File: rtl/mmio_bus_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker.
// On contention the master that did not win last time is chosen.
module rr_arb2
    import mmio_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_id,
    input  logic [1:0] mask,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic [1:0] elig;

    // pick the winner among the eligible requesters
    always_comb begin
        elig   = req & mask;
        gnt    = 2'b00;
        gnt_id = M0;
        if (elig == 2'b11) begin
            gnt_id = ~last_id;
        end else if (elig[1]) begin
            gnt_id = M1;
        end else begin
            gnt_id = M0;
        end
        if (elig != 2'b00) begin
            gnt = (gnt_id == M1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Two-master MMIO bus arbiter: IDLE -> ADDR -> DATA per transaction.
// Optional bus locking is built when MMIO_ARB_LOCK_EN is defined.
module mmio_bus_arbiter
    import mmio_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_lock,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_lock,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata
);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic          last_id_q;
    logic          lat_we_q;
    logic          lat_id_q;
    logic [AW-1:0] lat_addr_q;
    logic [DW-1:0] lat_wdata_q;
    logic [1:0]    arb_mask;
    logic [1:0]    arb_gnt;
    logic          arb_id;
    logic          accept;

`ifdef MMIO_ARB_LOCK_EN
    logic lock_held_q;
    logic lock_owner_q;

    // while locked only the owner may compete
    always_comb begin
        arb_mask = 2'b11;
        if (lock_held_q) begin
            arb_mask = (lock_owner_q == M1) ? 2'b10 : 2'b01;
        end
    end

    // lock follows the lock bit of each accepted request
    always_ff @(posedge CLK) begin
        if (reset) begin
            lock_held_q  <= 1'b0;
            lock_owner_q <= M0;
        end else if (accept) begin
            lock_held_q  <= arb_id ? m1_lock : m0_lock;
            lock_owner_q <= arb_id;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = m0_lock ^ m1_lock;
    assign arb_mask    = 2'b11;
`endif

    rr_arb2 u_arb (
        .req     ({m1_req, m0_req}),
        .last_id (last_id_q),
        .mask    (arb_mask),
        .gnt     (arb_gnt),
        .gnt_id  (arb_id)
    );

    assign accept = !reset && (state_q == ST_IDLE) && (arb_gnt != 2'b00);

    // state, round-robin history and latched winner request
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_id_q   <= M1;
            lat_we_q    <= 1'b0;
            lat_id_q    <= M0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_id_q   <= arb_id;
                lat_id_q    <= arb_id;
                lat_we_q    <= arb_id ? m1_we : m0_we;
                lat_addr_q  <= arb_id ? m1_addr : m0_addr;
                lat_wdata_q <= arb_id ? m1_wdata : m0_wdata;
            end
        end
    end

    // next state and bus outputs; everything quiet during reset
    always_comb begin
        state_d   = state_q;
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        s_we      = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ADDR;
                    m0_gnt  = arb_gnt[0];
                    m1_gnt  = arb_gnt[1];
                end
            end
            ST_ADDR: begin
                state_d = ST_DATA;
                if (!reset) begin
                    s_we    = lat_we_q;
                    s_addr  = lat_addr_q;
                    s_wdata = lat_wdata_q;
                end
            end
            ST_DATA: begin
                state_d = ST_IDLE;
                if (!reset) begin
                    if (lat_id_q == M1) begin
                        m1_rvalid = 1'b1;
                        m1_rdata  = s_rdata;
                    end else begin
                        m0_rvalid = 1'b1;
                        m0_rdata  = s_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Scoreboard bench for mmio_bus_arbiter with a GPIO slave model.
// Expected completions are queued at stimulus time, checked on rvalid.
module tb_mmio_bus_arbiter;
    import mmio_pkg::*;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 0, m0_we = 0, m0_lock = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic        m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_we;
    logic [31:0] s_addr, s_wdata;
    logic [31:0] s_rdata = 0;
    logic [31:0] gpio = 0;

    typedef struct {
        bit          id;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          gnt_log[$];
    int          cyc = 0;
    int          gnt_cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_gpio = 0;

    mmio_bus_arbiter #(.AW(32), .DW(32)) dut (
        .CLK(CLK), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // GPIO slave: one register, 1-cycle registered read
    always @(posedge CLK) begin
        if (reset) begin
            s_rdata <= 0;
        end else begin
            s_rdata <= (s_addr == GPIO_ADDR) ? gpio : 32'h0;
            if (s_we && s_addr == GPIO_ADDR) gpio <= s_wdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input bit id, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata);
        exp_t e;
        e.id    = id;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = (addr == GPIO_ADDR) ? m_gpio : 32'h0;
        if (we && addr == GPIO_ADDR) m_gpio = wdata;
        sb.push_back(e);
    endtask

    task automatic do_txn(input bit id, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit lock);
        bit got;
        got = 0;
        if (id) begin
            m1_req = 1; m1_we = we; m1_addr = addr;
            m1_wdata = wdata; m1_lock = lock;
        end else begin
            m0_req = 1; m0_we = we; m0_addr = addr;
            m0_wdata = wdata; m0_lock = lock;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            got = id ? m1_gnt : m0_gnt;
        end
        if (!got) check(id ? "gnt_timeout_m1" : "gnt_timeout_m0", 0, 1);
        @(posedge CLK);
        #1;
        if (id) begin
            m1_req = 0; m1_we = 0; m1_lock = 0;
        end else begin
            m0_req = 0; m0_we = 0; m0_lock = 0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge CLK);
        check("drain", sb.size(), 0);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (2) @(posedge CLK);
        #1;
        reset = 0;
    endtask

    // bus monitor: grant exclusivity, slave phase and completions
    always @(negedge CLK) begin
        if (!reset) begin
            if (m0_gnt || m1_gnt) begin
                check("one_gnt", m0_gnt & m1_gnt, 0);
                gnt_cyc = cyc;
                gnt_log.push_back(cyc);
            end
            if (s_we) begin
                if (sb.size() == 0) begin
                    check("spurious_we", 1, 0);
                end else begin
                    check("we_on_write", 1, sb[0].we);
                    check("s_addr", s_addr, sb[0].addr);
                    check("s_wdata", s_wdata, sb[0].wdata);
                    check("we_lat", cyc - gnt_cyc, 1);
                end
            end
            if (m0_rvalid || m1_rvalid) begin
                if (sb.size() == 0) begin
                    check("spurious_rvalid", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rv_id", {m1_rvalid, m0_rvalid},
                          mon_e.id ? 2'b10 : 2'b01);
                    check("rv_lat", cyc - gnt_cyc, 2);
                    if (!mon_e.we)
                        check("rdata", mon_e.id ? m1_rdata : m0_rdata,
                              mon_e.rdata);
                    check("loser_rdata", mon_e.id ? m0_rdata : m1_rdata, 0);
                end
            end
        end
    end

    initial begin
        int n0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_outs", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_we,
                           s_addr, m0_rdata[0], m1_rdata[0]}, 0);
        @(posedge CLK);
        #1;
        reset = 0;

        // write 1 to GPIO, then read back from m1
        push(0, 1, GPIO_ADDR, 32'h1);
        do_txn(0, 1, GPIO_ADDR, 32'h1, 0);
        drain();
        check("pin_after_wr", gpio, 32'h1);
        push(1, 0, GPIO_ADDR, 0);
        do_txn(1, 0, GPIO_ADDR, 0, 0);
        drain();
        push(1, 0, 32'h0, 0);
        do_txn(1, 0, 32'h0, 0, 0);
        drain();

        // contention straight after reset: m0, m1, m0, m1
        do_reset();
        push(0, 0, GPIO_ADDR, 0);
        push(1, 0, 32'h0, 0);
        push(0, 0, GPIO_ADDR, 0);
        push(1, 0, 32'h0, 0);
        n0 = gnt_log.size();
        fork
            begin
                do_txn(0, 0, GPIO_ADDR, 0, 0);
                do_txn(0, 0, GPIO_ADDR, 0, 0);
            end
            begin
                do_txn(1, 0, 32'h0, 0, 0);
                do_txn(1, 0, 32'h0, 0, 0);
            end
        join
        drain();
        check("rr_count", gnt_log.size() - n0, 4);
        if (gnt_log.size() - n0 == 4) begin
            for (int i = 1; i < 4; i++)
                check("rr_gap", gnt_log[n0+i] - gnt_log[n0+i-1], 3);
        end

        // reset in the ADDR phase of an m1 write drops it
        do_txn(1, 1, GPIO_ADDR, 32'h5, 0);
        reset = 1;
        @(negedge CLK);
        check("rst_addr_we", s_we, 0);
        check("rst_addr_rv", {m0_rvalid, m1_rvalid, m0_gnt, m1_gnt}, 0);
        @(posedge CLK);
        #1;
        reset = 0;
        repeat (3) begin
            @(negedge CLK);
            check("post_rst_quiet", {s_we, m1_rvalid}, 0);
        end
        check("pin_kept", gpio, 32'h1);
        check("sb_empty_rst", sb.size(), 0);

        // m0 locked read-modify-write against a waiting m1
        do_reset();
`ifdef MMIO_ARB_LOCK_EN
        push(0, 0, GPIO_ADDR, 0);
        push(0, 1, 32'h4, 32'h7);
        push(1, 0, 32'h0, 0);
`else
        push(0, 0, GPIO_ADDR, 0);
        push(1, 0, 32'h0, 0);
        push(0, 1, 32'h4, 32'h7);
`endif
        fork
            begin
                do_txn(0, 0, GPIO_ADDR, 0, 1);
                do_txn(0, 1, 32'h4, 32'h7, 0);
            end
            do_txn(1, 0, 32'h0, 0, 0);
        join
        drain();

        // idle bus stays quiet
        repeat (10) begin
            @(negedge CLK);
            check("idle", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_we,
                           s_addr}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
